// File: rtl/vector_processor_core_if.sv
// Sequencer-to-core bundle: instruction issue plus continuous register-file views.
interface vector_processor_core_if;
  localparam int unsigned INSTR_W = 13;
  localparam int unsigned VEC_W   = 512;

  logic               instr_valid;
  logic [INSTR_W-1:0] instruction;
  logic [VEC_W-1:0]   A1;
  logic [VEC_W-1:0]   A2;
  logic [VEC_W-1:0]   A3;
  logic [VEC_W-1:0]   A4;

  modport master (output instr_valid, instruction, input A1, A2, A3, A4);
  modport slave  (input instr_valid, instruction, output A1, A2, A3, A4);
endinterface

// File: rtl/vector_processor_core.sv
// Vector datapath: 4 x 512-bit register file, 512 x 32-bit data memory and a
// lane-wise signed add/multiply ALU, one instruction per cycle.
module vector_processor_core (
  input  logic                    clk,
  input  logic                    reset,
  vector_processor_core_if.slave  bus
);

  localparam int unsigned NUM_REGS  = 4;
  localparam int unsigned NUM_LANES = 16;
  localparam int unsigned LANE_W    = 32;
  localparam int unsigned VEC_W     = NUM_LANES * LANE_W;
  localparam int unsigned MEM_WORDS = 512;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned REG_IDX_W = 2;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_ADD   = 2'b10,
    OP_MUL   = 2'b11
  } opcode_e;

  logic [VEC_W-1:0]  vreg_q [NUM_REGS];
  logic [VEC_W-1:0]  vreg_d [NUM_REGS];
  logic [LANE_W-1:0] mem_q  [MEM_WORDS];
  logic [LANE_W-1:0] mem_d  [MEM_WORDS];

  opcode_e                op;
  logic [REG_IDX_W-1:0]   reg_idx;
  logic [ADDR_W-1:0]      base_addr;
  logic signed [LANE_W-1:0]   op_a;
  logic signed [LANE_W-1:0]   op_b;
  logic signed [2*LANE_W-1:0] full;

  assign op        = opcode_e'(bus.instruction[12:11]);
  assign reg_idx   = bus.instruction[10:9];
  assign base_addr = bus.instruction[8:0];

  // Next-state for registers and memory; 9-bit address arithmetic gives the wrap for free.
  always_comb begin
    vreg_d = vreg_q;
    mem_d  = mem_q;
    op_a   = '0;
    op_b   = '0;
    full   = '0;
    if (bus.instr_valid) begin
      unique case (op)
        OP_LOAD: begin
          for (int i = 0; i < NUM_LANES; i++) begin
            vreg_d[reg_idx][LANE_W*i +: LANE_W] = mem_q[base_addr + ADDR_W'(i)];
          end
        end
        OP_STORE: begin
          for (int i = 0; i < NUM_LANES; i++) begin
            mem_d[base_addr + ADDR_W'(i)] = vreg_q[reg_idx][LANE_W*i +: LANE_W];
          end
        end
        OP_ADD, OP_MUL: begin
          for (int i = 0; i < NUM_LANES; i++) begin
            op_a = vreg_q[0][LANE_W*i +: LANE_W];
            op_b = vreg_q[1][LANE_W*i +: LANE_W];
            if (op == OP_ADD) begin
              full = (2*LANE_W)'(op_a) + (2*LANE_W)'(op_b);
            end else begin
              full = (2*LANE_W)'(op_a) * (2*LANE_W)'(op_b);
            end
            vreg_d[2][LANE_W*i +: LANE_W] = full[LANE_W-1:0];
            vreg_d[3][LANE_W*i +: LANE_W] = full[2*LANE_W-1:LANE_W];
          end
        end
        default: ;
      endcase
    end
  end

  // Reset clears registers and reloads memory with its own word index.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        vreg_q[r] <= '0;
      end
      for (int k = 0; k < MEM_WORDS; k++) begin
        mem_q[k] <= LANE_W'(k);
      end
    end else begin
      vreg_q <= vreg_d;
      mem_q  <= mem_d;
    end
  end

  assign bus.A1 = vreg_q[0];
  assign bus.A2 = vreg_q[1];
  assign bus.A3 = vreg_q[2];
  assign bus.A4 = vreg_q[3];

endmodule

// File: tb/tb_vector_processor_core.sv
// Scoreboard bench: stimulus drives instructions and pushes expected register
// views from an array-based reference model; a monitor pops and compares.
module tb_vector_processor_core;

  logic clk = 1'b0;
  logic reset = 1'b1;

  vector_processor_core_if bus ();

  vector_processor_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state: plain integer arrays.
  int m_reg [4][16];
  int m_mem [512];

  logic [2047:0] exp_q [$];
  string         name_q [$];

  function automatic logic [12:0] mk(input int op, input int r, input int a);
    logic [12:0] v;
    v = {2'(op), 2'(r), 9'(a)};
    return v;
  endfunction

  function automatic logic [2047:0] snapshot();
    logic [2047:0] v;
    v = '0;
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 16; i++)
        v[512*r + 32*i +: 32] = m_reg[r][i];
    return v;
  endfunction

  task automatic model_step(input logic v, input logic rst, input logic [12:0] ins);
    int op, r, a;
    longint x, y, full;
    if (rst) begin
      for (int rr = 0; rr < 4; rr++)
        for (int i = 0; i < 16; i++) m_reg[rr][i] = 0;
      for (int k = 0; k < 512; k++) m_mem[k] = k;
    end else if (v) begin
      op = int'(ins[12:11]);
      r  = int'(ins[10:9]);
      a  = int'(ins[8:0]);
      case (op)
        0: for (int i = 0; i < 16; i++) m_reg[r][i] = m_mem[(a + i) % 512];
        1: for (int i = 0; i < 16; i++) m_mem[(a + i) % 512] = m_reg[r][i];
        default: begin
          for (int i = 0; i < 16; i++) begin
            x = longint'(m_reg[0][i]);
            y = longint'(m_reg[1][i]);
            full = (op == 2) ? x + y : x * y;
            m_reg[2][i] = int'(full);
            m_reg[3][i] = int'(full >>> 32);
          end
        end
      endcase
    end
  endtask

  // Drive one cycle of stimulus on the falling edge and record what must follow it.
  task automatic issue(input logic v, input logic rst, input logic [12:0] ins, input string name);
    @(negedge clk);
    reset = rst;
    bus.instr_valid = v;
    bus.instruction = ins;
    model_step(v, rst, ins);
    exp_q.push_back(snapshot());
    name_q.push_back(name);
  endtask

  function automatic logic [511:0] dut_reg(input int r);
    case (r)
      0: return bus.A1;
      1: return bus.A2;
      2: return bus.A3;
      default: return bus.A4;
    endcase
  endfunction

  // Monitor: every executed edge has exactly one expectation queued.
  initial begin
    logic [2047:0] e;
    logic [511:0]  got, want;
    string n;
    int lane;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        for (int r = 0; r < 4; r++) begin
          got  = dut_reg(r);
          want = e[512*r +: 512];
          tests_run++;
          if (got !== want) begin
            tests_failed++;
            lane = 0;
            for (int i = 15; i >= 0; i--)
              if (got[32*i +: 32] !== want[32*i +: 32]) lane = i;
            $display("FAIL %s A%0d lane %0d got %h required %h",
                     n, r + 1, lane, got[32*lane +: 32], want[32*lane +: 32]);
          end
        end
      end
    end
  end

  initial begin
    int drain;
    bus.instr_valid = 1'b0;
    bus.instruction = '0;

    issue(1'b0, 1'b1, mk(0, 0, 0), "reset0");
    issue(1'b1, 1'b1, mk(0, 0, 5), "reset_priority");

    issue(1'b1, 1'b0, mk(0, 0, 0),   "load_r0_a0");
    issue(1'b1, 1'b0, mk(0, 1, 16),  "load_r1_a16");
    issue(1'b1, 1'b0, mk(2, 0, 0),   "add");
    issue(1'b1, 1'b0, mk(0, 1, 505), "load_wrap_505");

    issue(1'b1, 1'b0, mk(0, 0, 256), "load_r0_a256");
    issue(1'b1, 1'b0, mk(0, 1, 256), "load_r1_a256");
    issue(1'b1, 1'b0, mk(3, 2, 77),  "mul_squares");
    issue(1'b1, 1'b0, mk(1, 2, 32),  "store_r2_a32");
    issue(1'b1, 1'b0, mk(0, 0, 32),  "load_r0_a32");
    issue(1'b1, 1'b0, mk(0, 1, 32),  "load_r1_a32");
    issue(1'b1, 1'b0, mk(3, 0, 0),   "mul_2pow32");

    issue(1'b1, 1'b0, mk(1, 3, 100), "store_r3_a100");
    issue(1'b1, 1'b0, mk(0, 0, 100), "load_r0_a100");
    issue(1'b1, 1'b0, mk(0, 1, 99),  "load_r1_a99");
    issue(1'b1, 1'b0, mk(0, 2, 101), "load_r2_a101");

    for (int k = 0; k < 3; k++)
      issue(1'b0, 1'b0, 13'($urandom), "valid_low");
    issue(1'b1, 1'b0, mk(0, 3, 32),  "mem_after_nop");

    issue(1'b1, 1'b0, mk(0, 0, 200), "pre_reset_load0");
    issue(1'b1, 1'b0, mk(0, 1, 300), "pre_reset_load1");
    issue(1'b1, 1'b1, mk(1, 0, 0),   "mid_reset");
    issue(1'b1, 1'b0, mk(0, 0, 0),   "post_reset_load");

    for (int k = 0; k < 400; k++)
      issue(($urandom_range(0, 7) != 0), ($urandom_range(0, 63) == 0),
            13'($urandom), "random");

    @(negedge clk);
    bus.instr_valid = 1'b0;
    reset = 1'b0;
    drain = 0;
    while (exp_q.size() > 0 && drain < 5) begin
      @(negedge clk);
      drain++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain pending %0d required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
